reg_status_file: RTL and testbench
==================================

# reg_status_file

Architectural register file with per-register ROB tag and busy tracking. It sits directly downstream of the reorder buffer.
- Issue side: marks a destination register busy with the allocating ROB tag.
- Commit side: retires data into the register and clears busy only when the committing tag still owns the register.
- Flush side: clears busy bits for squashed tags during branch-mispredict recovery.
- Read side: read ports feed the reservation stations with either a value or the tag to wait on.

## Interface
Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero)
- TAG_W, 3, ROB tag width (8 ROB entries)
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_en  in  1  issue allocates a destination this cycle
- alloc_rd  in  5  destination register of issuing instruction
- alloc_tag  in  TAG_W  ROB entry assigned (ROB curr_ptr)
- commit_en  in  1  ROB commits a register-writing instruction (regfile_load)
- commit_rd  in  5  committing destination (rd_commit)
- commit_tag  in  TAG_W  ROB head pointer of committing entry
- commit_data  in  XLEN  result value of committing entry
- flush_vld  in  8x1  per ROB entry: entry is squashed (set_reg_valid)
- flush_rd  in  8x5  per ROB entry: its destination register (reg_valid)
- rs1_idx, rs2_idx  in  5 each  source register indices from issue
- rs1_data, rs2_data  out  XLEN  source values
- rs1_busy, rs2_busy  out  1  source still awaiting a ROB result
- rs1_tag, rs2_tag  out  TAG_W  ROB tag producing the source when busy
- busy_cnt  out  6  registered count of busy registers

## Operation
- State per register r: data[r] (XLEN), busy[r], tag[r]. Register x0 is never busy, always reads 0, and ignores alloc and commit.
- Allocate (alloc_en & alloc_rd!=0): next busy[alloc_rd]=1, tag[alloc_rd]=alloc_tag. This overwrites any older tag (renaming to the youngest writer).
- Commit (commit_en & commit_rd!=0):
  - data[commit_rd] is always written.
  - busy[commit_rd] is cleared only if tag[commit_rd]==commit_tag. Otherwise a younger writer still owns it and busy/tag are unchanged.
- Flush: for each i in 0..7 with flush_vld[i], if busy[flush_rd[i]] and tag[flush_rd[i]]==i, then next busy[flush_rd[i]]=0. Data is unchanged. Multiple flush lanes may target the same register; the effect is their OR.
- Next-state priority for busy/tag of a given register: alloc > flush > commit clear. Alloc and commit to the same rd in one cycle: data is written, and busy=1 with tag=alloc_tag.
- Read port n (combinational):
  - If idx==0: data=0, busy=0, tag=0.
  - Else if commit_en & commit_rd==idx & tag[idx]==commit_tag & busy[idx]: data=commit_data, busy=0 (commit bypass).
  - Otherwise: data=data[idx], busy=busy[idx], tag=tag[idx].
  - Reads never see the same-cycle alloc; issue logic handles the rs==rd of the same instruction.
- busy_cnt: the popcount of busy[1..NREG-1], registered (reflects state after the previous edge). Range 0..31.

## Timing
- Reset: all data=0, busy=0, tag=0, busy_cnt=0. Consequently every read output is 0 or not-busy in the first cycle after reset.
- rst mid-operation discards all pending busy state in one cycle and ignores that cycle's alloc, commit and flush.
- Alloc, commit and flush take effect at the next rising edge. Reads in the following cycle observe the new state.
- Commit data is visible on read ports in the same cycle via the bypass (zero-latency forward).
- Flush lanes act in one cycle. The ROB may assert them on consecutive cycles during a flush; each cycle is independent.
- Tag wrap-around: tags are compared for equality only, with no ordering. A stale commit with a reused tag value matches only if the register truly still carries that tag.

## Test plan
- Reset, then read x5 and x0 -> data 0, busy 0, busy_cnt 0.
- Alloc x5 tag 2. Next cycle read x5 -> busy 1, tag 2. Commit x5 tag 2 data 0xDEADBEEF -> same-cycle read returns 0xDEADBEEF with busy 0; next cycle busy 0 and busy_cnt 0.
- Alloc x7 tag 1, then alloc x7 tag 4, then commit x7 tag 1 data 0x11 -> data=0x11, busy stays 1 with tag 4. Commit x7 tag 4 data 0x22 -> busy 0, data 0x22.
- Alloc x3 tag 5, x4 tag 6. Assert flush_vld[5], flush_vld[6] with rd 3/4 -> both busy cleared, data unchanged, busy_cnt 0. Flush lane 2 with rd 3 while tag[3]=5 -> no change.
- Same cycle alloc x9 tag 3 and commit x9 tag 0 data 0x55 (tag[9]=0, busy) -> data 0x55, busy 1, tag 3.
- Alloc x0 tag 1 and commit x0 data 0xFF -> x0 reads 0, not busy, busy_cnt unchanged. Assert rst mid-stream with 4 busy registers -> all clear next cycle.

Source files
------------

// File: rtl/reg_status_file.sv
// Architectural register file with per-register ROB tag/busy tracking.
// Issue marks busy, commit retires data, flush squashes, reads forward commits.
module reg_status_file #(
  parameter int NREG  = 32,
  parameter int TAG_W = 3,
  parameter int XLEN  = 32,
  localparam int RW   = $clog2(NREG),
  localparam int NROB = 1 << TAG_W,
  localparam int CW   = $clog2(NREG) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic [RW-1:0]             alloc_rd,
  input  logic [TAG_W-1:0]          alloc_tag,
  input  logic                      commit_en,
  input  logic [RW-1:0]             commit_rd,
  input  logic [TAG_W-1:0]          commit_tag,
  input  logic [XLEN-1:0]           commit_data,
  input  logic [NROB-1:0]           flush_vld,
  input  logic [NROB-1:0][RW-1:0]   flush_rd,
  input  logic [RW-1:0]             rs1_idx,
  input  logic [RW-1:0]             rs2_idx,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [TAG_W-1:0]          rs1_tag,
  output logic [TAG_W-1:0]          rs2_tag,
  output logic [CW-1:0]             busy_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rd_port_t;

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [NREG-1:0]  busy_q;

  logic [XLEN-1:0]  data_n [NREG];
  logic [TAG_W-1:0] tag_n  [NREG];
  logic [NREG-1:0]  busy_n;
  logic [CW-1:0]    cnt_n;

  // Later assignments win, so the update order encodes commit < flush < alloc.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    busy_n = busy_q;
    for (int r = 0; r < NREG; r++) begin
      data_n[r] = data_q[r];
      tag_n[r]  = tag_q[r];
    end

    if (commit_en && commit_rd != '0) begin
      data_n[commit_rd] = commit_data;
      if (tag_q[commit_rd] == commit_tag) busy_n[commit_rd] = 1'b0;
    end

    for (int i = 0; i < NROB; i++) begin
      if (flush_vld[i] && busy_q[flush_rd[i]] && tag_q[flush_rd[i]] == TAG_W'(i))
        busy_n[flush_rd[i]] = 1'b0;
    end

    if (alloc_en && alloc_rd != '0) begin
      busy_n[alloc_rd] = 1'b1;
      tag_n[alloc_rd]  = alloc_tag;
    end

    busy_n[0] = 1'b0;

    cnt_n = '0;
    for (int r = 1; r < NREG; r++) cnt_n = cnt_n + CW'(busy_n[r]);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the data array is reset too, because reads must return 0 after
      // reset; a plain RAM without reset would not meet that.
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= data_n[r];
        tag_q[r]  <= tag_n[r];
      end
      busy_q   <= busy_n;
      busy_cnt <= cnt_n;
    end
  end

  // Commit bypass forwards the retiring value only when it clears ownership.
  function automatic rd_port_t read_port(input logic [RW-1:0] idx);
    rd_port_t p;
    p = '0;
    if (idx != '0) begin
      if (commit_en && commit_rd == idx && tag_q[idx] == commit_tag && busy_q[idx]) begin
        p.data = commit_data;
      end else begin
        p.data = data_q[idx];
        p.busy = busy_q[idx];
        p.tag  = tag_q[idx];
      end
    end
    return p;
  endfunction

  rd_port_t rs1_p, rs2_p;

  always_comb begin
    rs1_p = read_port(rs1_idx);
    rs2_p = read_port(rs2_idx);
  end

  assign rs1_data = rs1_p.data;
  assign rs1_busy = rs1_p.busy;
  assign rs1_tag  = rs1_p.tag;
  assign rs2_data = rs2_p.data;
  assign rs2_busy = rs2_p.busy;
  assign rs2_tag  = rs2_p.tag;

endmodule

// File: tb/tb_reg_status_file.sv
// Directed self-checking bench for reg_status_file: alloc, commit bypass,
// renaming, flush, same-cycle alloc/commit, x0 and mid-stream reset.
module tb_reg_status_file;

  logic            clk;
  logic            rst;
  logic            alloc_en;
  logic [4:0]      alloc_rd;
  logic [2:0]      alloc_tag;
  logic            commit_en;
  logic [4:0]      commit_rd;
  logic [2:0]      commit_tag;
  logic [31:0]     commit_data;
  logic [7:0]      flush_vld;
  logic [7:0][4:0] flush_rd;
  logic [4:0]      rs1_idx, rs2_idx;
  logic [31:0]     rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic [2:0]      rs1_tag, rs2_tag;
  logic [5:0]      busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  reg_status_file dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data),
    .flush_vld(flush_vld), .flush_rd(flush_rd),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    alloc_en = 0; alloc_rd = 0; alloc_tag = 0;
    commit_en = 0; commit_rd = 0; commit_tag = 0; commit_data = 0;
    flush_vld = 0; flush_rd = '0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rs1_idx = 0; rs2_idx = 0;
    step(); step();
    rst = 0; rs1_idx = 5; rs2_idx = 0; settle();
    n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL reset_x5_data got %h exp 0", rs1_data); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_x5_busy got %b exp 0", rs1_busy); end
    n_cmp++; if (rs2_data !== 32'h0 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL reset_x0 got %h/%b exp 0/0", rs2_data, rs2_busy); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_busy_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_commit_bypass();
    alloc_en = 1; alloc_rd = 5; alloc_tag = 2;
    step(); rs1_idx = 5; settle();
    n_cmp++; if (rs1_busy !== 1'b1 || rs1_tag !== 3'd2) begin n_err++; $display("FAIL alloc_x5 got busy %b tag %0d exp 1/2", rs1_busy, rs1_tag); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL alloc_x5_cnt got %0d exp 1", busy_cnt); end
    commit_en = 1; commit_rd = 5; commit_tag = 2; commit_data = 32'hDEADBEEF; settle();
    n_cmp++; if (rs1_data !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin n_err++; $display("FAIL bypass_x5 got %h/%b exp deadbeef/0", rs1_data, rs1_busy); end
    step(); settle();
    n_cmp++; if (rs1_data !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin n_err++; $display("FAIL commit_x5 got %h/%b exp deadbeef/0", rs1_data, rs1_busy); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL commit_x5_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_rename();
    rs1_idx = 7;
    alloc_en = 1; alloc_rd = 7; alloc_tag = 1; step();
    alloc_en = 1; alloc_rd = 7; alloc_tag = 4; step(); settle();
    n_cmp++; if (rs1_busy !== 1'b1 || rs1_tag !== 3'd4) begin n_err++; $display("FAIL rename_x7 got busy %b tag %0d exp 1/4", rs1_busy, rs1_tag); end
    commit_en = 1; commit_rd = 7; commit_tag = 1; commit_data = 32'h11; settle();
    n_cmp++; if (rs1_data !== 32'h0 || rs1_busy !== 1'b1) begin n_err++; $display("FAIL stale_no_bypass got %h/%b exp 0/1", rs1_data, rs1_busy); end
    step(); settle();
    n_cmp++; if (rs1_data !== 32'h11 || rs1_busy !== 1'b1 || rs1_tag !== 3'd4) begin n_err++; $display("FAIL stale_commit got %h/%b/%0d exp 11/1/4", rs1_data, rs1_busy, rs1_tag); end
    commit_en = 1; commit_rd = 7; commit_tag = 4; commit_data = 32'h22;
    step(); settle();
    n_cmp++; if (rs1_data !== 32'h22 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL owner_commit got %h/%b exp 22/0", rs1_data, rs1_busy); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL rename_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_flush();
    rs1_idx = 3; rs2_idx = 4;
    commit_en = 1; commit_rd = 3; commit_tag = 0; commit_data = 32'h33; step();
    alloc_en = 1; alloc_rd = 3; alloc_tag = 5; step();
    alloc_en = 1; alloc_rd = 4; alloc_tag = 6; step(); settle();
    n_cmp++; if (busy_cnt !== 6'd2) begin n_err++; $display("FAIL flush_pre_cnt got %0d exp 2", busy_cnt); end
    flush_vld[2] = 1; flush_rd[2] = 5'd3; step(); settle();
    n_cmp++; if (rs1_busy !== 1'b1 || rs1_tag !== 3'd5 || busy_cnt !== 6'd2) begin n_err++; $display("FAIL flush_wrong_lane got %b/%0d/%0d exp 1/5/2", rs1_busy, rs1_tag, busy_cnt); end
    flush_vld[5] = 1; flush_rd[5] = 5'd3; flush_vld[6] = 1; flush_rd[6] = 5'd4;
    step(); settle();
    n_cmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL flush_clear got %b/%b exp 0/0", rs1_busy, rs2_busy); end
    n_cmp++; if (rs1_data !== 32'h33) begin n_err++; $display("FAIL flush_data got %h exp 33", rs1_data); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL flush_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_alloc_commit_same();
    rs1_idx = 9;
    alloc_en = 1; alloc_rd = 9; alloc_tag = 0; step();
    alloc_en = 1; alloc_rd = 9; alloc_tag = 3;
    commit_en = 1; commit_rd = 9; commit_tag = 0; commit_data = 32'h55; settle();
    n_cmp++; if (rs1_data !== 32'h55 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL same_cycle_bypass got %h/%b exp 55/0", rs1_data, rs1_busy); end
    step(); settle();
    n_cmp++; if (rs1_data !== 32'h55 || rs1_busy !== 1'b1 || rs1_tag !== 3'd3) begin n_err++; $display("FAIL alloc_wins got %h/%b/%0d exp 55/1/3", rs1_data, rs1_busy, rs1_tag); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL alloc_wins_cnt got %0d exp 1", busy_cnt); end
  endtask

  task automatic test_x0();
    rs1_idx = 0;
    alloc_en = 1; alloc_rd = 0; alloc_tag = 1;
    commit_en = 1; commit_rd = 0; commit_tag = 0; commit_data = 32'hFF; settle();
    n_cmp++; if (rs1_data !== 32'h0 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL x0_same_cycle got %h/%b exp 0/0", rs1_data, rs1_busy); end
    step(); settle();
    n_cmp++; if (rs1_data !== 32'h0 || rs1_busy !== 1'b0 || rs1_tag !== 3'd0) begin n_err++; $display("FAIL x0_read got %h/%b/%0d exp 0/0/0", rs1_data, rs1_busy, rs1_tag); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL x0_cnt got %0d exp 1", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    alloc_en = 1; alloc_rd = 10; alloc_tag = 1; step();
    alloc_en = 1; alloc_rd = 11; alloc_tag = 2; step();
    alloc_en = 1; alloc_rd = 12; alloc_tag = 4; step(); settle();
    n_cmp++; if (busy_cnt !== 6'd4) begin n_err++; $display("FAIL pre_reset_cnt got %0d exp 4", busy_cnt); end
    rst = 1;
    alloc_en = 1; alloc_rd = 13; alloc_tag = 5;
    commit_en = 1; commit_rd = 9; commit_tag = 3; commit_data = 32'h99;
    step(); rst = 0; rs1_idx = 9; rs2_idx = 13; settle();
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_mid_cnt got %0d exp 0", busy_cnt); end
    n_cmp++; if (rs1_data !== 32'h0 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_x9 got %h/%b exp 0/0", rs1_data, rs1_busy); end
    n_cmp++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_x13 got %b exp 0", rs2_busy); end
    rs1_idx = 10; settle();
    n_cmp++; if (rs1_busy !== 1'b0 || rs1_tag !== 3'd0) begin n_err++; $display("FAIL reset_mid_x10 got %b/%0d exp 0/0", rs1_busy, rs1_tag); end
  endtask

  initial begin
    rst = 1; idle(); rs1_idx = 0; rs2_idx = 0;
    test_reset();
    test_commit_bypass();
    test_rename();
    test_flush();
    test_alloc_commit_same();
    test_x0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
